// File: rtl/periph_arb_pkg.sv
// Shared types for the two-master peripheral bus arbiter.
// Included by periph_arb_rr2 and periph_bus_arbiter.
package periph_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_e;

    typedef enum logic {
        MST_CORE,
        MST_SPI
    } arb_mst_e;

    localparam logic [31:0] ARB_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/periph_arb_rr2.sv
// Two-way round-robin pick: sole requester wins, a tie goes
// to the master that was not served last.
module periph_arb_rr2
    import periph_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  arb_mst_e   last_i,
    output arb_mst_e   win_o
);

    always_comb begin
        win_o = MST_CORE;
        unique case (1'b1)
            (req_i == 2'b10): win_o = MST_SPI;
            (req_i == 2'b11): win_o = (last_i == MST_CORE) ? MST_SPI : MST_CORE;
            default:          win_o = MST_CORE;
        endcase
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing the peripheral bus between core and SPI bridge.
// Optional response timeout enabled by defining PERIPH_ARB_TIMEOUT_EN.
module periph_bus_arbiter
    import periph_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             m_req_i,
    input  logic [1:0]             m_we_i,
    input  logic [1:0][DW/8-1:0]   m_be_i,
    input  logic [1:0][AW-1:0]     m_addr_i,
    input  logic [1:0][DW-1:0]     m_wdata_i,
    output logic [1:0]             m_gnt_o,
    output logic [1:0]             m_rvalid_o,
    output logic [DW-1:0]          m_rdata_o,
    output logic                   m_err_o,
    output logic                   s_req_o,
    output logic                   s_we_o,
    output logic [DW/8-1:0]        s_be_o,
    output logic [AW-1:0]          s_addr_o,
    output logic [DW-1:0]          s_wdata_o,
    input  logic                   s_gnt_i,
    input  logic                   s_rvalid_i,
    input  logic [DW-1:0]          s_rdata_i
);

    arb_state_e    state_q, state_d;
    arb_mst_e      owner_q, owner_d;
    arb_mst_e      last_q, last_d;
    arb_mst_e      winner;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          ow;
    logic          in_req;
    logic          in_wait;
    logic          gnt_hit;
    logic          rsp_ok;
    logic          rsp_to;
    logic          rsp;
    logic [1:0]    ow_vec;

    periph_arb_rr2 u_rr (
        .req_i  (m_req_i),
        .last_i (last_q),
        .win_o  (winner)
    );

    assign ow      = (owner_q == MST_SPI);
    assign ow_vec  = ow ? 2'b10 : 2'b01;
    assign in_req  = (state_q == ARB_REQ) && !rst_i;
    assign in_wait = (state_q == ARB_WAIT) && !rst_i;
    assign gnt_hit = in_req && s_gnt_i;
    assign rsp_ok  = in_wait && s_rvalid_i;

`ifdef PERIPH_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // Count is zero on the first WAIT cycle since it idles at zero elsewhere.
    assign cnt_d  = (state_q == ARB_WAIT) ? cnt_q + 16'd1 : 16'd0;
    assign rsp_to = in_wait && !s_rvalid_i
                    && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_tmo;

    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign rsp_to     = 1'b0;
`endif

    assign rsp = rsp_ok || rsp_to;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (|m_req_i) begin
                    owner_d = winner;
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (s_gnt_i) begin
                    last_d  = owner_q;
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (rsp) begin
                    rdata_d = rsp_ok ? s_rdata_i : DW'(ARB_ERR_RDATA);
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            owner_q <= MST_CORE;
            last_q  <= MST_SPI;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

    assign m_gnt_o    = gnt_hit ? ow_vec : 2'b00;
    assign m_rvalid_o = rsp ? ow_vec : 2'b00;
    // rdata_d carries the response value during the response cycle.
    assign m_rdata_o  = rsp ? rdata_d : rdata_q;
    assign m_err_o    = rsp_to;

    assign s_req_o   = in_req;
    assign s_we_o    = in_req && m_we_i[ow];
    assign s_be_o    = in_req ? m_be_i[ow] : '0;
    assign s_addr_o  = in_req ? m_addr_i[ow] : '0;
    assign s_wdata_o = in_req ? m_wdata_i[ow] : '0;

    a_req_held: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (state_q == ARB_REQ) |-> m_req_i[ow]
    );

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Randomized and directed checks of periph_bus_arbiter against
// a cycle-level behavioural model of the arbitration rules.
module tb_periph_bus_arbiter;

`ifdef PERIPH_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      m_req = '0;
    logic [1:0]      m_we = '0;
    logic [1:0][3:0] m_be = '0;
    logic [1:0][31:0] m_addr = '0;
    logic [1:0][31:0] m_wdata = '0;
    logic [1:0]      m_gnt_o;
    logic [1:0]      m_rvalid_o;
    logic [31:0]     m_rdata_o;
    logic            m_err_o;
    logic            s_req_o;
    logic            s_we_o;
    logic [3:0]      s_be_o;
    logic [31:0]     s_addr_o;
    logic [31:0]     s_wdata_o;
    logic            s_gnt = 1'b0;
    logic            s_rvalid = 1'b0;
    logic [31:0]     s_rdata = '0;

    int n_chk = 0;
    int n_err = 0;

    int          mdl_ph = 0;
    int          mdl_own = 0;
    int          mdl_last = 1;
    int          mdl_cnt = 0;
    logic [31:0] mdl_rdata = '0;

    logic [1:0]  t_gnt, t_rv;
    logic        t_sreq, t_we, t_err;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [1:0]  gnt_log[$];

    always #5 clk = ~clk;

    periph_bus_arbiter #(
        .AW(32), .DW(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m_req_i    (m_req),
        .m_we_i     (m_we),
        .m_be_i     (m_be),
        .m_addr_i   (m_addr),
        .m_wdata_i  (m_wdata),
        .m_gnt_o    (m_gnt_o),
        .m_rvalid_o (m_rvalid_o),
        .m_rdata_o  (m_rdata_o),
        .m_err_o    (m_err_o),
        .s_req_o    (s_req_o),
        .s_we_o     (s_we_o),
        .s_be_o     (s_be_o),
        .s_addr_o   (s_addr_o),
        .s_wdata_o  (s_wdata_o),
        .s_gnt_i    (s_gnt),
        .s_rvalid_i (s_rvalid),
        .s_rdata_i  (s_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic set_m(input int i, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd);
        m_req[i]   = 1'b1;
        m_we[i]    = we;
        m_be[i]    = be;
        m_addr[i]  = addr;
        m_wdata[i] = wd;
    endtask

    // One bus cycle: compare against the model, advance it, release granted masters.
    task automatic tick();
        logic [1:0]  eg, ev;
        logic        ee, es, ew;
        logic [3:0]  eb;
        logic [31:0] ed, ea, ewd;
        #1;
        eg = '0; ev = '0; ee = 1'b0; es = 1'b0; ew = 1'b0;
        eb = '0; ea = '0; ewd = '0; ed = mdl_rdata;
        if (!rst && mdl_ph == 1) begin
            es  = 1'b1;
            ew  = m_we[mdl_own];
            eb  = m_be[mdl_own];
            ea  = m_addr[mdl_own];
            ewd = m_wdata[mdl_own];
            if (s_gnt) eg[mdl_own] = 1'b1;
        end
        if (!rst && mdl_ph == 2) begin
            if (s_rvalid) begin
                ev[mdl_own] = 1'b1;
                ed = s_rdata;
            end else if (TO_EN && mdl_cnt == TMO - 1) begin
                ev[mdl_own] = 1'b1;
                ee = 1'b1;
                ed = 32'hDEAD_BEEF;
            end
        end
        t_gnt = m_gnt_o; t_rv = m_rvalid_o; t_sreq = s_req_o;
        t_we = s_we_o; t_err = m_err_o; t_addr = s_addr_o;
        t_wdata = s_wdata_o; t_rdata = m_rdata_o;
        if (!rst) begin
            if (m_gnt_o != 2'b00) gnt_log.push_back(m_gnt_o);
            chk("gnt", 64'(m_gnt_o), 64'(eg));
            chk("rvalid", 64'(m_rvalid_o), 64'(ev));
            chk("rdata", 64'(m_rdata_o), 64'(ed));
            chk("err", 64'(m_err_o), 64'(ee));
            chk("s_req", 64'(s_req_o), 64'(es));
            chk("s_we", 64'(s_we_o), 64'(ew));
            chk("s_be", 64'(s_be_o), 64'(eb));
            chk("s_addr", 64'(s_addr_o), 64'(ea));
            chk("s_wdata", 64'(s_wdata_o), 64'(ewd));
        end
        @(posedge clk);
        if (rst) begin
            mdl_ph = 0; mdl_own = 0; mdl_last = 1;
            mdl_cnt = 0; mdl_rdata = '0;
        end else begin
            if (ev != 2'b00) mdl_rdata = ed;
            case (mdl_ph)
                0: if (m_req != 2'b00) begin
                    if (m_req == 2'b11) mdl_own = 1 - mdl_last;
                    else mdl_own = m_req[1] ? 1 : 0;
                    mdl_ph = 1;
                end
                1: if (s_gnt) begin
                    mdl_last = mdl_own;
                    mdl_ph = 2;
                    mdl_cnt = 0;
                end
                default: if (ev != 2'b00) mdl_ph = 0;
                         else mdl_cnt++;
            endcase
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) if (eg[i]) m_req[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        gnt_log.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();
        tick();
        chk("rst_sreq", 64'(t_sreq), 64'd0);
        chk("rst_gnt", 64'(t_gnt), 64'd0);
        chk("rst_rv", 64'(t_rv), 64'd0);
        chk("rst_rdata", 64'(t_rdata), 64'd0);
        chk("rst_err", 64'(t_err), 64'd0);

        // SPI write, zero-wait slave
        do_reset();
        set_m(1, 1'b1, 4'hF, 32'h3001_0014, 32'h0000_00FF);
        s_gnt = 1'b1; s_rvalid = 1'b1;
        tick();
        chk("t1_idle_sreq", 64'(t_sreq), 64'd0);
        tick();
        chk("t1_sreq", 64'(t_sreq), 64'd1);
        chk("t1_gnt", 64'(t_gnt), 64'h2);
        chk("t1_addr", 64'(t_addr), 64'h3001_0014);
        chk("t1_wdata", 64'(t_wdata), 64'hFF);
        chk("t1_we", 64'(t_we), 64'd1);
        tick();
        chk("t1_rv", 64'(t_rv), 64'h2);

        // Tie after reset alternates M0, M1, M0, M1
        do_reset();
        set_m(0, 1'b0, 4'hF, 32'h3001_0000, 32'h0);
        set_m(1, 1'b1, 4'h3, 32'h3001_0004, 32'h55);
        s_gnt = 1'b1; s_rvalid = 1'b1;
        for (int c = 0; c < 30 && gnt_log.size() < 4; c++) begin
            tick();
            m_req = 2'b11;
        end
        chk("t2_count", 64'(gnt_log.size()), 64'd4);
        if (gnt_log.size() >= 4) begin
            chk("t2_g0", 64'(gnt_log[0]), 64'h1);
            chk("t2_g1", 64'(gnt_log[1]), 64'h2);
            chk("t2_g2", 64'(gnt_log[2]), 64'h1);
            chk("t2_g3", 64'(gnt_log[3]), 64'h2);
        end

        // Core read, slow slave, SPI arrives mid-way
        do_reset();
        set_m(0, 1'b0, 4'hF, 32'h3001_0008, 32'h0);
        s_gnt = 1'b1; s_rvalid = 1'b0;
        tick(); tick();
        chk("t3_core_gnt", 64'(t_gnt), 64'h1);
        set_m(1, 1'b1, 4'hF, 32'h3001_0014, 32'h1);
        tick();
        chk("t3_hold0", 64'(t_gnt), 64'h0);
        tick();
        chk("t3_hold1", 64'(t_gnt), 64'h0);
        s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
        tick();
        chk("t3_rv", 64'(t_rv), 64'h1);
        chk("t3_rdata", 64'(t_rdata), 64'h1234_5678);
        chk("t3_hold2", 64'(t_gnt), 64'h0);
        s_rvalid = 1'b0; s_rdata = 32'hA5A5_A5A5;
        tick();
        chk("t3_rdata_held", 64'(t_rdata), 64'h1234_5678);
        tick();
        chk("t3_spi_gnt", 64'(t_gnt), 64'h2);

        // Reset while waiting drops the response
        do_reset();
        set_m(0, 1'b0, 4'hF, 32'h3001_0010, 32'h0);
        s_gnt = 1'b1;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0BAD_0BAD;
        tick();
        chk("t4_no_rv", 64'(t_rv), 64'h0);
        chk("t4_sreq", 64'(t_sreq), 64'h0);
        s_rvalid = 1'b0;
        set_m(0, 1'b0, 4'hF, 32'h3001_0000, 32'h0);
        set_m(1, 1'b1, 4'hF, 32'h3001_0004, 32'h7);
        tick(); tick();
        chk("t4_tie_m0", 64'(t_gnt), 64'h1);

`ifdef PERIPH_ARB_TIMEOUT_EN
        // Slave never responds
        do_reset();
        set_m(0, 1'b0, 4'hF, 32'h3001_0020, 32'h0);
        s_gnt = 1'b1; s_rvalid = 1'b0;
        tick(); tick();
        s_gnt = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            tick();
            if (k < TMO) chk("t5_early", 64'(t_rv), 64'h0);
        end
        chk("t5_rv", 64'(t_rv), 64'h1);
        chk("t5_err", 64'(t_err), 64'h1);
        chk("t5_rdata", 64'(t_rdata), 64'hDEAD_BEEF);
        s_rvalid = 1'b1;
        tick();
        chk("t5_late", 64'(t_rv), 64'h0);
        s_rvalid = 1'b0;
`endif

        // Back-to-back SPI writes with a stalled slave grant
        do_reset();
        set_m(1, 1'b1, 4'hF, 32'h3001_0030, 32'hAAAA_0001);
        s_gnt = 1'b0; s_rvalid = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_stall_a", 64'(t_addr), 64'h3001_0030);
            chk("t6_nognt_a", 64'(t_gnt), 64'h0);
        end
        s_gnt = 1'b1;
        tick();
        set_m(1, 1'b1, 4'h1, 32'h3001_0034, 32'hAAAA_0002);
        s_gnt = 1'b0;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6_stall_b", 64'(t_wdata), 64'hAAAA_0002);
        end
        s_gnt = 1'b1;
        tick();
        chk("t6_gnt_b", 64'(t_gnt), 64'h2);
        chk("t6_pulses", 64'(gnt_log.size()), 64'd2);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++)
                if (!m_req[i] && $urandom_range(2) == 0)
                    set_m(i, 1'($urandom), 4'($urandom), $urandom, $urandom);
            s_gnt    = 1'($urandom);
            s_rvalid = ($urandom_range(2) == 0);
            s_rdata  = $urandom;
            rst      = ($urandom_range(199) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
